data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder_pkg.sv | 8 +
 rtl/data_mem_responder_byte_lane_ram.sv | 23 ++
 rtl/data_mem_responder.sv | 85 ++++++++
 tb/tb_data_mem_responder.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared FSM encodings and lane constants for the data-memory responder.
package data_mem_responder_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [3:0] MASK_READ = 4'b0000;
  localparam int LANE_W = 8;
endpackage

// File: rtl/data_mem_responder_byte_lane_ram.sv
// byte_lane_ram: four byte-wide arrays with per-lane write enable and a registered read port.
module byte_lane_ram
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk_i,
  input  logic [3:0]                     we_i,
  input  logic                           re_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [31:0]                    wdata_i,
  output logic [31:0]                    rdata_o
);
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [LANE_W-1:0] mem_q [DEPTH_WORDS];
    logic [LANE_W-1:0] rd_q;
    always_ff @(posedge clk_i) begin
      if (we_i[i]) mem_q[addr_i] <= wdata_i[i*LANE_W +: LANE_W];
      if (re_i) rd_q <= mem_q[addr_i];
    end
    assign rdata_o[i*LANE_W +: LANE_W] = rd_q;
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding data-memory responder with optional wait states.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [31:0] ReqAddr,
  input  logic [3:0]  ReqMask,
  input  logic [31:0] ReqWData,
  output logic        RspValid,
  input  logic        RspReady,
  output logic [31:0] RspData,
  output logic        RspErr
);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q;
  logic          inr_q;
  logic [3:0]    mask_q;
  logic [31:0]   wdata_q;
  logic [31:0]   off, rdata, acc_wdata;
  logic          req_inr, req_xfer, acc, acc_inr;
  logic [3:0]    acc_mask;
  logic [AW-1:0] acc_idx;
  assign off      = ReqAddr - BASE_ADDR;
  assign req_inr  = ReqAddr >= BASE_ADDR && off < (32'(DEPTH_WORDS) << 2);
  assign req_xfer = ReqValid && ReqReady;
  // The access happens at the accept edge with no wait states, else on the last wait cycle.
  assign acc       = WAIT_STATES == 0 ? req_xfer : state_q == ST_WAIT && cnt_q == 4'd1;
  assign acc_idx   = state_q == ST_IDLE ? off[AW+1:2] : idx_q;
  assign acc_inr   = state_q == ST_IDLE ? req_inr : inr_q;
  assign acc_mask  = state_q == ST_IDLE ? ReqMask : mask_q;
  assign acc_wdata = state_q == ST_IDLE ? ReqWData : wdata_q;
  byte_lane_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk_i  (CLK),
    .we_i   (acc && acc_inr ? acc_mask : 4'b0000),
    .re_i   (acc && acc_inr && acc_mask == MASK_READ),
    .addr_i (acc_idx),
    .wdata_i(acc_wdata),
    .rdata_o(rdata)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_IDLE && ReqValid) begin
      state_d = WAIT_STATES == 0 ? ST_RESP : ST_WAIT;
      cnt_d   = 4'(WAIT_STATES);
    end
    if (state_q == ST_WAIT) begin
      cnt_d   = cnt_q - 4'd1;
      state_d = cnt_q == 4'd1 ? ST_RESP : ST_WAIT;
    end
    if (state_q == ST_RESP && RspReady) state_d = ST_IDLE;
  end
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      inr_q   <= 1'b0;
      mask_q  <= 4'b0000;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (req_xfer) begin
        idx_q   <= off[AW+1:2];
        inr_q   <= req_inr;
        mask_q  <= ReqMask;
        wdata_q <= ReqWData;
      end
    end
  end
  assign ReqReady = state_q == ST_IDLE;
  assign RspValid = state_q == ST_RESP;
  assign RspErr   = state_q == ST_RESP && !inr_q;
  assign RspData  = state_q == ST_RESP && inr_q && mask_q == MASK_READ ? rdata : 32'd0;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized and directed checks of two responders (0 and 3 wait states) against a word-array model.
module tb_data_mem_responder;
  localparam int DEPTH = 64;
  localparam logic [31:0] B0 = 32'h0000_0000;
  localparam logic [31:0] B1 = 32'h0000_1000;
  logic CLK = 1'b0;
  logic RESETn = 1'b0;
  logic r_v [2], q_rdy [2], q_v [2], p_r [2], q_e [2];
  logic [31:0] r_a [2], r_wd [2], q_d [2];
  logic [3:0] r_m [2];
  logic [31:0] model [2][DEPTH];
  int n_chk = 0, n_pass = 0;
  always #5 CLK = ~CLK;
  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .BASE_ADDR(B0)) u0 (
    .CLK(CLK), .RESETn(RESETn), .ReqValid(r_v[0]), .ReqReady(q_rdy[0]), .ReqAddr(r_a[0]),
    .ReqMask(r_m[0]), .ReqWData(r_wd[0]), .RspValid(q_v[0]), .RspReady(p_r[0]),
    .RspData(q_d[0]), .RspErr(q_e[0]));
  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3), .BASE_ADDR(B1)) u3 (
    .CLK(CLK), .RESETn(RESETn), .ReqValid(r_v[1]), .ReqReady(q_rdy[1]), .ReqAddr(r_a[1]),
    .ReqMask(r_m[1]), .ReqWData(r_wd[1]), .RspValid(q_v[1]), .RspReady(p_r[1]),
    .RspData(q_d[1]), .RspErr(q_e[1]));
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask
  function automatic logic [31:0] base_of(input int d);
    return d != 0 ? B1 : B0;
  endfunction
  function automatic bit in_rng(input int d, input logic [31:0] a);
    return a >= base_of(d) && (a - base_of(d)) / 4 < DEPTH;
  endfunction
  task automatic xact(input int d, input logic [31:0] addr, input logic [3:0] mask,
                      input logic [31:0] wd, input int hold, input bit chk_data,
                      input bit junk, output logic [31:0] got);
    int k, idx, w;
    bit inr;
    logic [31:0] exp, held, nw;
    w = d != 0 ? 3 : 0;
    inr = in_rng(d, addr);
    idx = int'((addr - base_of(d)) / 4);
    exp = inr && mask == 4'b0000 ? model[d][idx] : 32'd0;
    got = 32'd0;
    @(negedge CLK);
    chk("req_ready_idle", 32'(q_rdy[d]), 32'd1);
    r_v[d] = 1'b1; r_a[d] = addr; r_m[d] = mask; r_wd[d] = wd; p_r[d] = 1'b0;
    @(posedge CLK);
    for (k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (k == 1 && junk) begin
        r_m[d] = 4'hF; r_wd[d] = ~wd;
      end else r_v[d] = 1'b0;
      if (q_v[d]) break;
      chk("req_ready_wait", 32'(q_rdy[d]), 32'd0);
    end
    r_v[d] = 1'b0;
    if (k > 40) begin
      chk("rsp_timeout", 32'(q_v[d]), 32'd1);
      return;
    end
    chk("latency", 32'(k), 32'(w + 1));
    chk("rsp_err", 32'(q_e[d]), 32'(!inr));
    if (chk_data) chk("rsp_data", q_d[d], exp);
    got = q_d[d];
    held = q_d[d];
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      chk("hold_valid", 32'(q_v[d]), 32'd1);
      chk("hold_data", q_d[d], held);
      chk("hold_ready", 32'(q_rdy[d]), 32'd0);
    end
    p_r[d] = 1'b1;
    @(negedge CLK);
    p_r[d] = 1'b0;
    chk("post_valid", 32'(q_v[d]), 32'd0);
    chk("post_ready", 32'(q_rdy[d]), 32'd1);
    chk("post_data", q_d[d], 32'd0);
    if (inr && mask != 4'b0000) begin
      nw = model[d][idx];
      for (int i = 0; i < 4; i++) if (mask[i]) nw[8*i +: 8] = wd[8*i +: 8];
      model[d][idx] = nw;
    end
  endtask
  initial begin
    logic [31:0] got, a;
    logic [3:0] m;
    for (int d = 0; d < 2; d++) begin
      r_v[d] = 1'b0; r_a[d] = 32'd0; r_m[d] = 4'd0; r_wd[d] = 32'd0; p_r[d] = 1'b0;
    end
    repeat (3) begin
      @(negedge CLK);
      chk("rst_ready0", 32'(q_rdy[0]), 32'd1);
      chk("rst_ready1", 32'(q_rdy[1]), 32'd1);
      chk("rst_valid", 32'(q_v[0] | q_v[1]), 32'd0);
      chk("rst_err", 32'(q_e[0] | q_e[1]), 32'd0);
      chk("rst_data", q_d[0] | q_d[1], 32'd0);
    end
    RESETn = 1'b1;
    xact(0, 32'h10, 4'h0, 32'd0, 0, 1'b0, 1'b0, got);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++) xact(d, base_of(d) + 32'(4 * i), 4'hF, $urandom, 0, 1'b1, 1'b0, got);
    xact(0, 32'h4, 4'hF, 32'hAABBCCDD, 0, 1'b1, 1'b0, got);
    xact(0, 32'h4, 4'b0100, 32'h0011_0000, 0, 1'b1, 1'b0, got);
    xact(0, 32'h4, 4'h0, 32'd0, 0, 1'b1, 1'b0, got);
    chk("byte_write", got, 32'hAA11CCDD);
    xact(0, 32'h8, 4'hF, 32'h12345678, 0, 1'b1, 1'b0, got);
    xact(0, 32'h8, 4'b0101, 32'hFFFFFFFF, 0, 1'b1, 1'b0, got);
    xact(0, 32'h8, 4'h0, 32'd0, 5, 1'b1, 1'b0, got);
    chk("noncontig_mask", got, 32'h12FF56FF);
    xact(0, B0 + 32'(4 * DEPTH), 4'hF, 32'hCAFEF00D, 2, 1'b1, 1'b0, got);
    xact(0, B0 + 32'(4 * (DEPTH - 1)), 4'h0, 32'd0, 0, 1'b1, 1'b0, got);
    xact(1, B1 + 32'h10, 4'hF, 32'h5A5A_A5A5, 0, 1'b1, 1'b1, got);
    xact(1, B1 + 32'h10, 4'h0, 32'd0, 1, 1'b1, 1'b0, got);
    chk("ws_readback", got, 32'h5A5A_A5A5);
    xact(1, B1 - 32'd4, 4'hF, 32'h1, 0, 1'b1, 1'b0, got);
    @(negedge CLK);
    r_v[1] = 1'b1; r_a[1] = B1 + 32'h20; r_m[1] = 4'hF; r_wd[1] = 32'hDEADBEEF;
    @(posedge CLK);
    @(negedge CLK);
    r_v[1] = 1'b0;
    chk("mid_wait_ready", 32'(q_rdy[1]), 32'd0);
    @(negedge CLK);
    #1 RESETn = 1'b0;
    #1 chk("async_rst_ready", 32'(q_rdy[1]), 32'd1);
    repeat (2) @(negedge CLK);
    RESETn = 1'b1;
    repeat (6) begin
      @(negedge CLK);
      chk("no_rsp_after_rst", 32'(q_v[1]), 32'd0);
    end
    xact(1, B1 + 32'h20, 4'h0, 32'd0, 0, 1'b1, 1'b0, got);
    for (int d = 0; d < 2; d++)
      for (int n = 0; n < 60; n++) begin
        a = base_of(d) + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0)
          a = (d != 0 && $urandom_range(0, 1) == 1) ? base_of(d) - 32'($urandom_range(1, 16))
                                                    : base_of(d) + 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
        m = $urandom_range(0, 1) == 1 ? 4'h0 : 4'($urandom);
        xact(d, a, m, $urandom, $urandom_range(0, 2), 1'b1, d != 0 && $urandom_range(0, 1) == 1, got);
      end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
